layer_output_serializer: RTL and testbench

//   Sits between layer N's bank of neuron instances and layer N+1's shared input bus. Collects
//   one result per neuron, each flagged by that neuron's outvalid pulse, into a capture bank.

---
 rtl/layer_output_serializer_if.sv | 13 +
 rtl/layer_output_serializer.sv | 123 ++++++++++++
 tb/tb_layer_output_serializer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_output_serializer_if.sv
// Stream bus from a layer serializer to the next layer's shared input.
//   out_data   streamed word (next layer myinput)
//   out_valid  word qualifier (next layer myinputValid)
// master: serializer side (drives); slave: next-layer side (observes).
interface layer_output_serializer_if #(
  parameter int unsigned dataWidth = 16
);
  logic [dataWidth-1:0] out_data;
  logic                 out_valid;

  modport master (output out_data, output out_valid);
  modport slave  (input  out_data, input  out_valid);
endinterface

// File: rtl/layer_output_serializer.sv
// Collects one result per neuron into a capture bank, then streams the
// complete frame one word per cycle (neuron 0 first) onto the next layer's
// input bus. A second (stream) bank lets the next frame be captured while
// the current one is streaming.
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   neuron_out    packed neuron results, neuron i at [i*dataWidth +: dataWidth]
//   neuron_valid  per-neuron result strobes
//   stream        master side of the out_data/out_valid bus
//   busy          streaming, or a complete frame is waiting to stream
//   overrun       sticky: a neuron delivered again before its slot was consumed
module layer_output_serializer #(
  parameter int unsigned numNeurons = 30,
  parameter int unsigned dataWidth  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [numNeurons*dataWidth-1:0] neuron_out,
  input  logic [numNeurons-1:0]          neuron_valid,
  layer_output_serializer_if.master      stream,
  output logic                           busy,
  output logic                           overrun
);

  localparam int unsigned IDX_W = $clog2(numNeurons);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(numNeurons - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state, state_next;
  logic [numNeurons-1:0] mask;
  logic                 pend, pend_next;
  logic [IDX_W-1:0]     idx;
  logic [dataWidth-1:0] cap_data [numNeurons];
  logic [dataWidth-1:0] cap_next [numNeurons];
  logic [dataWidth-1:0] bank     [numNeurons];
  logic                 complete;
  logic                 at_last;
  logic                 load, advance, stop;

  // Capture bank as it will be after this edge (same-cycle arrivals included).
  always_comb begin
    for (int i = 0; i < int'(numNeurons); i++) begin
      cap_next[i] = neuron_valid[i] ? neuron_out[i*dataWidth +: dataWidth] : cap_data[i];
    end
  end

  assign complete = &(mask | neuron_valid);
  assign at_last  = (idx == LAST_IDX);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and datapath controls.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    stop       = 1'b0;
    case (state)
      IDLE: begin
        if (complete) begin
          load       = 1'b1;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (!at_last) begin
          advance = 1'b1;
        end else if (pend || complete) begin
          // A frame completing on the last word is chained without a gap too.
          load = 1'b1;
        end else begin
          stop       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    pend_next = load ? 1'b0 : (pend | ((state == STREAM) & complete));
  end

  // Capture bank, stream bank, index and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask             <= '0;
      pend             <= 1'b0;
      idx              <= '0;
      busy             <= 1'b0;
      overrun          <= 1'b0;
      stream.out_data  <= '0;
      stream.out_valid <= 1'b0;
      for (int i = 0; i < int'(numNeurons); i++) begin
        cap_data[i] <= '0;
        bank[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < int'(numNeurons); i++) cap_data[i] <= cap_next[i];
      // Mask clears only when the bank is handed over to the stream bank.
      mask    <= load ? '0 : (mask | neuron_valid);
      overrun <= overrun | (|(neuron_valid & mask));
      pend    <= pend_next;
      busy    <= (state_next == STREAM) | pend_next;
      if (load) begin
        for (int i = 0; i < int'(numNeurons); i++) bank[i] <= cap_next[i];
        idx              <= '0;
        stream.out_data  <= cap_next[0];
        stream.out_valid <= 1'b1;
      end else if (advance) begin
        idx              <= idx + IDX_W'(1);
        stream.out_data  <= bank[idx + IDX_W'(1)];
        stream.out_valid <= 1'b1;
      end else if (stop) begin
        idx              <= '0;
        stream.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_layer_output_serializer.sv
// Bench for layer_output_serializer: a 4-neuron instance for directed frames
// and a 30-neuron instance for randomised frames, both checked every cycle
// against a frame-queue model, plus literal expectations at key cycles.
module tb_layer_output_serializer;

  localparam int unsigned DW = 16;
  localparam int unsigned NA = 4;
  localparam int unsigned NB = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NA*DW-1:0] nd_a = '0;
  logic [NA-1:0]    nv_a = '0;
  logic [NB*DW-1:0] nd_b = '0;
  logic [NB-1:0]    nv_b = '0;
  logic busy_a, ovr_a, busy_b, ovr_b;

  layer_output_serializer_if #(.dataWidth(DW)) bus_a ();
  layer_output_serializer_if #(.dataWidth(DW)) bus_b ();

  layer_output_serializer #(.numNeurons(NA), .dataWidth(DW)) dut_a (
    .clk(clk), .rst(rst), .neuron_out(nd_a), .neuron_valid(nv_a),
    .stream(bus_a.master), .busy(busy_a), .overrun(ovr_a));

  layer_output_serializer #(.numNeurons(NB), .dataWidth(DW)) dut_b (
    .clk(clk), .rst(rst), .neuron_out(nd_b), .neuron_valid(nv_b),
    .stream(bus_b.master), .busy(busy_b), .overrun(ovr_b));

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model: each completed frame is appended to a word queue; the bus shows
  // the queue head, one word popped per cycle.
  logic [DW-1:0] m_cap  [2][NB];
  logic [NB-1:0] m_mask [2];
  logic [DW-1:0] m_q    [2][256];
  logic [7:0]    m_hd   [2];
  logic [7:0]    m_tl   [2];
  logic          m_ovr  [2];
  logic [DW-1:0] m_last [2];
  int            m_n;
  logic          m_full;

  function automatic logic in_valid(input int k, input int i);
    return (k == 0) ? nv_a[i] : nv_b[i];
  endfunction

  function automatic logic [DW-1:0] in_data(input int k, input int i);
    return (k == 0) ? nd_a[i*DW +: DW] : nd_b[i*DW +: DW];
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_mask[k] = '0;
        m_hd[k]   = '0;
        m_tl[k]   = '0;
        m_ovr[k]  = 1'b0;
        m_last[k] = '0;
      end else begin
        m_n = (k == 0) ? NA : NB;
        if (m_hd[k] != m_tl[k]) m_hd[k] = m_hd[k] + 8'd1;
        for (int i = 0; i < m_n; i++) begin
          if (in_valid(k, i)) begin
            if (m_mask[k][i]) m_ovr[k] = 1'b1;
            m_cap[k][i]  = in_data(k, i);
            m_mask[k][i] = 1'b1;
          end
        end
        m_full = 1'b1;
        for (int i = 0; i < m_n; i++) m_full = m_full & m_mask[k][i];
        if (m_full) begin
          for (int i = 0; i < m_n; i++) begin
            m_q[k][m_tl[k]] = m_cap[k][i];
            m_tl[k] = m_tl[k] + 8'd1;
          end
          m_mask[k] = '0;
        end
        if (m_hd[k] != m_tl[k]) m_last[k] = m_q[k][m_hd[k]];
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    check("A out_valid", 32'(bus_a.out_valid), 32'(m_hd[0] != m_tl[0]));
    check("A out_data",  32'(bus_a.out_data),  32'(m_last[0]));
    check("A busy",      32'(busy_a),          32'(m_hd[0] != m_tl[0]));
    check("A overrun",   32'(ovr_a),           32'(m_ovr[0]));
    check("B out_valid", 32'(bus_b.out_valid), 32'(m_hd[1] != m_tl[1]));
    check("B out_data",  32'(bus_b.out_data),  32'(m_last[1]));
    check("B busy",      32'(busy_b),          32'(m_hd[1] != m_tl[1]));
    check("B overrun",   32'(ovr_b),           32'(m_ovr[1]));
  end

  int words_b = 0;
  always @(negedge clk) if (bus_b.out_valid === 1'b1) words_b++;

  task automatic put_a(input logic [NA-1:0] v, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                       input logic [DW-1:0] w2, input logic [DW-1:0] w3);
    nv_a = v;
    nd_a = {w3, w2, w1, w0};
  endtask

  logic [DW-1:0] e1 [4];
  logic [DW-1:0] e3 [8];
  int            slot_a [4];
  int            slot_b [NB];

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("reset out_valid", 32'(bus_a.out_valid), 32'd0);
    check("reset out_data",  32'(bus_a.out_data),  32'd0);
    check("reset busy",      32'(busy_a),          32'd0);
    check("reset overrun",   32'(ovr_a),           32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: all four results in one cycle.
    e1 = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    put_a(4'hF, e1[0], e1[1], e1[2], e1[3]);
    @(negedge clk);
    put_a(4'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    for (int j = 0; j < 4; j++) begin
      check("t1 valid", 32'(bus_a.out_valid), 32'd1);
      check("t1 data",  32'(bus_a.out_data),  32'(e1[j]));
      check("t1 busy",  32'(busy_a),          32'd1);
      @(negedge clk);
    end
    check("t1 valid end", 32'(bus_a.out_valid), 32'd0);
    check("t1 busy end",  32'(busy_a),          32'd0);
    check("t1 data hold", 32'(bus_a.out_data),  32'h0044);
    check("t1 overrun",   32'(ovr_a),           32'd0);

    // 2: staggered arrivals n2@0, n0@3, n3@5, n1@9.
    slot_a = '{3, 9, 0, 5};
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < 4; i++) nv_a[i] = (slot_a[i] == c);
      nd_a = {16'h0A03, 16'h0A02, 16'h0A01, 16'h0A00};
      check("t2 no early valid", 32'(bus_a.out_valid), 32'd0);
      @(negedge clk);
    end
    nv_a = '0;
    for (int j = 0; j < 4; j++) begin
      check("t2 valid", 32'(bus_a.out_valid), 32'd1);
      check("t2 data",  32'(bus_a.out_data),  32'(16'h0A00 + 16'(j)));
      @(negedge clk);
    end
    check("t2 valid end", 32'(bus_a.out_valid), 32'd0);
    repeat (2) @(negedge clk);

    // 3: second frame completes while the first streams.
    e3 = '{16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0201, 16'h0202, 16'h0203, 16'h0204};
    for (int j = 0; j < 10; j++) begin
      if (j == 0)      put_a(4'hF, e3[0], e3[1], e3[2], e3[3]);
      else if (j == 2) put_a(4'hF, e3[4], e3[5], e3[6], e3[7]);
      else             nv_a = '0;
      if (j >= 1 && j <= 8) begin
        check("t3 valid", 32'(bus_a.out_valid), 32'd1);
        check("t3 busy",  32'(busy_a),          32'd1);
        check("t3 data",  32'(bus_a.out_data),  32'(e3[j-1]));
      end else if (j == 9) begin
        check("t3 valid end", 32'(bus_a.out_valid), 32'd0);
        check("t3 busy end",  32'(busy_a),          32'd0);
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);

    // 4: n1 delivered twice before the frame completes.
    for (int j = 0; j < 9; j++) begin
      if (j == 0)      put_a(4'b0010, 16'h0, 16'h0AAA, 16'h0, 16'h0);
      else if (j == 1) put_a(4'b0010, 16'h0, 16'h0BBB, 16'h0, 16'h0);
      else if (j == 2) put_a(4'b1101, 16'h0C00, 16'h0, 16'h0C02, 16'h0C03);
      else             nv_a = '0;
      if (j == 3) begin
        check("t4 overrun", 32'(ovr_a),           32'd1);
        check("t4 word0",   32'(bus_a.out_data),  32'h0C00);
      end
      if (j == 4) check("t4 word1", 32'(bus_a.out_data), 32'h0BBB);
      if (j == 8) check("t4 overrun sticky", 32'(ovr_a), 32'd1);
      @(negedge clk);
    end

    // 5: asynchronous reset in the middle of a stream.
    put_a(4'hF, 16'h0501, 16'h0502, 16'h0503, 16'h0504);
    @(negedge clk);
    nv_a = '0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5 rst valid",   32'(bus_a.out_valid), 32'd0);
    check("t5 rst data",    32'(bus_a.out_data),  32'd0);
    check("t5 rst busy",    32'(busy_a),          32'd0);
    check("t5 rst overrun", 32'(ovr_a),           32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t5 no valid after rst", 32'(bus_a.out_valid), 32'd0);
    end
    put_a(4'hF, 16'h0601, 16'h0602, 16'h0603, 16'h0604);
    @(negedge clk);
    nv_a = '0;
    check("t5 new valid", 32'(bus_a.out_valid), 32'd1);
    check("t5 new data",  32'(bus_a.out_data),  32'h0601);
    repeat (6) @(negedge clk);

    // 6: 100 frames on the 30-neuron instance, random order and values.
    for (int f = 0; f < 100; f++) begin
      for (int i = 0; i < int'(NB); i++) begin
        slot_b[i] = int'($urandom_range(0, 2*NB - 1));
        nd_b[i*DW +: DW] = DW'($urandom);
      end
      for (int c = 0; c < int'(2*NB); c++) begin
        for (int i = 0; i < int'(NB); i++) nv_b[i] = (slot_b[i] == c);
        @(negedge clk);
      end
    end
    nv_b = '0;
    repeat (3*NB) @(negedge clk);
    check("t6 word count", 32'(words_b), 32'd3000);
    check("t6 overrun",    32'(ovr_b),   32'd0);
    check("t6 busy end",   32'(busy_b),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
